// File: rtl/seq_store_reg.sv
// seq_store_reg: sequence store for the game datapath.
// DEPTH words of WIDTH bits are appended at the tail and then replayed through
// a replay pointer. rd_data/rd_valid/at_end/full are combinational from the
// registered length and pointer. overflow/match/mismatch are registered pulses.
// Optional feature: define SEQ_STORE_COMPARE_EN to add the guess comparator
// (guess/guess_vld inputs, match/mismatch pulses, auto-advance on match).
module seq_store_reg #(
    parameter int WIDTH  = 2,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              rewind,
    input  logic              next,
`ifdef SEQ_STORE_COMPARE_EN
    input  logic [WIDTH-1:0]  guess,
    input  logic              guess_vld,
    output logic              match,
    output logic              mismatch,
`endif
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              at_end,
    output logic [ADDR_W:0]   length,
    output logic              full,
    output logic              overflow
);

    localparam int LW = ADDR_W + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    rp_q;
    logic             wr_en;
    logic             step;

    // Read side: pointer below length means a live word; otherwise output zeros.
    assign rd_valid = (rp_q < len_q);
    assign at_end   = ~rd_valid;
    assign full     = (len_q == DEPTH_L);
    assign length   = len_q;
    assign rd_data  = rd_valid ? mem[rp_q[ADDR_W-1:0]] : '0;

    // A rejected push (store full) or a clear in the same cycle writes nothing.
    assign wr_en = push & ~full & ~clear;

`ifdef SEQ_STORE_COMPARE_EN
    logic cmp_hit;
    logic cmp_miss;

    // A guess against an exhausted sequence always counts as a mismatch.
    assign cmp_hit  = guess_vld & rd_valid & (guess == rd_data);
    assign cmp_miss = guess_vld & ~cmp_hit;
    // next and a matching guess together still move the pointer by one.
    assign step     = rd_valid & (next | cmp_hit);

    // Comparator result pulses, one cycle after the guess strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            match    <= cmp_hit;
            mismatch <= cmp_miss;
        end
    end
`else
    assign step = rd_valid & next;
`endif

    // Storage array: written only at the tail; clear leaves contents in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[len_q[ADDR_W-1:0]] <= push_data;
        end
    end

    // Length counter and overflow pulse; clear outranks push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push & full & ~clear;
            if (clear)      len_q <= '0;
            else if (wr_en) len_q <= len_q + 1'b1;
        end
    end

    // Replay pointer: clear > rewind > step; step is qualified on pre-edge length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rp_q <= '0;
        end else if (clear | rewind) begin
            rp_q <= '0;
        end else if (step) begin
            rp_q <= rp_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_store_reg.sv
// Self-checking bench for seq_store_reg against a behavioural store model
// (array + integer length/pointer), directed scenarios plus a random soak.
module tb_seq_store_reg;

    localparam int W  = 2;
    localparam int D  = 32;
    localparam int A  = 5;
    localparam int LW = A + 1;
    localparam int OW = LW + 4 + W;

    logic          clk = 1'b0;
    logic          reset, clear, push, rewind, next;
    logic [W-1:0]  push_data;
    logic [W-1:0]  rd_data;
    logic          rd_valid, at_end, full, overflow;
    logic [LW-1:0] length;
`ifdef SEQ_STORE_COMPARE_EN
    logic [W-1:0]  guess;
    logic          guess_vld, match, mismatch;
`endif

    seq_store_reg #(.WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
        .clk(clk), .reset(reset), .clear(clear), .push(push),
        .push_data(push_data), .rewind(rewind), .next(next),
`ifdef SEQ_STORE_COMPARE_EN
        .guess(guess), .guess_vld(guess_vld), .match(match), .mismatch(mismatch),
`endif
        .rd_data(rd_data), .rd_valid(rd_valid), .at_end(at_end),
        .length(length), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    logic [W-1:0] m_mem [D];
    int           m_len, m_rp;
    logic         m_ovf, m_match, m_mis;

    wire [OW-1:0] obs = {length, rd_valid, at_end, full, overflow, rd_data};

    function automatic logic [OW-1:0] exp_vec();
        logic v;
        logic [W-1:0] d;
        v = (m_rp < m_len);
        d = v ? m_mem[m_rp] : '0;
        return {LW'(m_len), v, ~v, (m_len == D), m_ovf, d};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_len = 0; m_rp = 0; m_ovf = 0; m_match = 0; m_mis = 0;
    endtask

    // Drive one cycle of inputs, advance the model by the store rules, sample #1 after edge.
    task automatic cyc(input logic c, input logic p, input logic [W-1:0] d,
                       input logic rw, input logic nx,
                       input logic gv = 1'b0, input logic [W-1:0] g = '0);
        logic pv, hit;
        clear = c; push = p; push_data = d; rewind = rw; next = nx;
`ifdef SEQ_STORE_COMPARE_EN
        guess = g; guess_vld = gv;
`endif
        @(posedge clk);
        pv = (m_rp < m_len);
`ifdef SEQ_STORE_COMPARE_EN
        hit = gv && pv && (g == m_mem[m_rp]);
        m_match = hit;
        m_mis = gv && !hit;
`else
        hit = 1'b0;
        if (gv || g != '0) hit = 1'b0;
`endif
        m_ovf = p && !c && (m_len == D);
        if (c) begin
            m_len = 0; m_rp = 0;
        end else begin
            if (p && m_len < D) begin
                m_mem[m_len] = d;
                m_len++;
            end
            if (rw) m_rp = 0;
            else if (pv && (nx || hit)) m_rp++;
        end
        #1;
        clear = 0; push = 0; push_data = '0; rewind = 0; next = 0;
`ifdef SEQ_STORE_COMPARE_EN
        guess = '0; guess_vld = 0;
`endif
    endtask

    task automatic test_reset();
        // clock edges have not happened yet: reset is asserted from time 0
        #2;
        n_vec++;
        if (obs !== {LW'(0), 1'b0, 1'b1, 1'b0, 1'b0, W'(0)}) begin
            n_err++; $display("FAIL reset_state: got %h want %h", obs, exp_vec());
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_replay();
        logic [W-1:0] seq [3];
        seq[0] = 2'd2; seq[1] = 2'd0; seq[2] = 2'd3;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, seq[i], 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (rd_data !== seq[i] || obs !== exp_vec()) begin
                n_err++; $display("FAIL replay_%0d: got %h want %h (rd %0d want %0d)",
                                  i, obs, exp_vec(), rd_data, seq[i]);
            end
            cyc(0, 0, 0, 0, 1);
        end
        n_vec++;
        if (at_end !== 1'b1 || rd_valid !== 1'b0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL replay_end: got %h want %h", obs, exp_vec());
        end
        // extra next must not move rp past length: a new push becomes readable at rp=3
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 2'd1, 0, 0);
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== 2'd1 || obs !== exp_vec()) begin
            n_err++; $display("FAIL replay_no_overrun: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_full();
        logic [W-1:0] last;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < D; i++) cyc(0, 1, W'($urandom), 0, 0);
        n_vec++;
        if (full !== 1'b1 || length !== LW'(D) || obs !== exp_vec()) begin
            n_err++; $display("FAIL full_flag: got %h want %h", obs, exp_vec());
        end
        last = m_mem[D-1];
        cyc(0, 1, ~last, 0, 0);
        n_vec++;
        if (overflow !== 1'b1 || length !== LW'(D) || obs !== exp_vec()) begin
            n_err++; $display("FAIL overflow_pulse: got %h want %h", obs, exp_vec());
        end
        cyc(0, 0, 0, 0, 0);
        n_vec++;
        if (overflow !== 1'b0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL overflow_one_cycle: got %h want %h", obs, exp_vec());
        end
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < D - 1; i++) cyc(0, 0, 0, 0, 1);
        n_vec++;
        if (rd_data !== last || obs !== exp_vec()) begin
            n_err++; $display("FAIL last_word_kept: got %0d want %0d", rd_data, last);
        end
    endtask

    task automatic test_same_cycle();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 2'd3, 0, 0);
        cyc(1, 1, 2'd2, 0, 0);
        n_vec++;
        if (length !== LW'(0) || obs !== exp_vec()) begin
            n_err++; $display("FAIL push_clear: got %h want %h", obs, exp_vec());
        end
        // length=0: next is ignored, push lands
        cyc(0, 1, 2'd1, 0, 1);
        n_vec++;
        if (length !== LW'(1) || rd_data !== 2'd1 || obs !== exp_vec()) begin
            n_err++; $display("FAIL push_next_empty: got %h want %h", obs, exp_vec());
        end
        // length=1, rp=0: both take effect, rp=1 points at the new word
        cyc(0, 1, 2'd2, 0, 1);
        n_vec++;
        if (length !== LW'(2) || rd_data !== 2'd2 || obs !== exp_vec()) begin
            n_err++; $display("FAIL push_next: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, W'(i + 1), 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
        n_vec++;
        if (rd_data !== 2'd0 || length !== LW'(5) || obs !== exp_vec()) begin
            n_err++; $display("FAIL pre_reset: got %h want %h", obs, exp_vec());
        end
        @(negedge clk);
        #2 reset = 1;
        m_reset();
        #1;
        n_vec++;
        if (length !== LW'(0) || at_end !== 1'b1 || obs !== exp_vec()) begin
            n_err++; $display("FAIL async_reset: got %h want %h", obs, exp_vec());
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0), W'($urandom),
                ($urandom_range(0, 14) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0), W'($urandom));
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL random_%0d: got %h want %h", i, obs, exp_vec());
            end
`ifdef SEQ_STORE_COMPARE_EN
            n_vec++;
            if ({match, mismatch} !== {m_match, m_mis}) begin
                n_err++; $display("FAIL random_cmp_%0d: got %b%b want %b%b",
                                  i, match, mismatch, m_match, m_mis);
            end
`endif
        end
    endtask

`ifdef SEQ_STORE_COMPARE_EN
    task automatic test_compare();
        logic [W-1:0] g [4];
        logic [1:0]   want [4];
        g[0] = 2'd1; g[1] = 2'd3; g[2] = 2'd2; g[3] = 2'd0;
        want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b10; want[3] = 2'b01;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 2'd1, 0, 0);
        cyc(0, 1, 2'd2, 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 1'b1, g[i]);
            n_vec++;
            if ({match, mismatch} !== want[i] || obs !== exp_vec()) begin
                n_err++; $display("FAIL compare_%0d: got %b%b/%h want %b/%h",
                                  i, match, mismatch, obs, want[i], exp_vec());
            end
        end
        n_vec++;
        if (at_end !== 1'b1) begin
            n_err++; $display("FAIL compare_end: got at_end %b want 1", at_end);
        end
    endtask
`endif

    initial begin
        reset = 1; clear = 0; push = 0; push_data = '0; rewind = 0; next = 0;
`ifdef SEQ_STORE_COMPARE_EN
        guess = '0; guess_vld = 0;
`endif
        m_reset();
        test_reset();
        test_replay();
        test_full();
        test_same_cycle();
        test_reset_mid();
`ifdef SEQ_STORE_COMPARE_EN
        test_compare();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
